gfx_host_bridge: RTL and testbench

- Host-side bus initiator for the graphics adapter's register port; generates the 1 MHz bus clock, active-low chip select, 4-bit register select, active-low write enable and the data bus.
- Internal logic queues register read and write requests in a small FIFO and converts each one into one bus cycle on the adapter's bus.
- Read data sampled from the adapter is returned on a response strobe.
- Used as the adapter's host in soft-CPU builds and as the stimulus master in system benches.

---
 rtl/gfx_host_bridge_if.sv | 35 +++
 rtl/gfx_host_bridge.sv | 122 ++++++++++++
 tb/tb_gfx_host_bridge.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gfx_host_bridge_if.sv
// gfx_host_bridge_if: request/response handshake and adapter register-bus
// signals for gfx_host_bridge.
//   slave  : the bridge side (accepts requests, drives the adapter bus).
//   master : the requester/adapter side (offers requests, supplies data_i).
interface gfx_host_bridge_if;
  // request / response
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [3:0] req_rs;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  // adapter bus
  logic       bus_clk;
  logic       cs_n;
  logic [3:0] rs;
  logic       wren_n;
  logic [7:0] data_o;
  logic       data_oe;
  logic [7:0] data_i;

  modport slave (
    input  req_valid, req_write, req_rs, req_wdata, data_i,
    output req_ready, rsp_valid, rsp_rdata, busy,
           bus_clk, cs_n, rs, wren_n, data_o, data_oe
  );

  modport master (
    output req_valid, req_write, req_rs, req_wdata, data_i,
    input  req_ready, rsp_valid, rsp_rdata, busy,
           bus_clk, cs_n, rs, wren_n, data_o, data_oe
  );
endinterface

// File: rtl/gfx_host_bridge.sv
// gfx_host_bridge: host-side initiator for the graphics adapter register port.
// Queues register read/write requests in a small FIFO and turns each into one
// bus_clk period on the adapter bus (low phase: address/control, high phase:
// adapter latches or drives data). Read data is returned on a one-clk strobe.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : gfx_host_bridge_if.slave (req_*, rsp_*, busy, adapter bus)
module gfx_host_bridge #(
  parameter int HALF_PERIOD = 25,  // clk cycles per bus_clk phase (>=2)
  parameter int FIFO_DEPTH  = 4    // power of two, >=2
) (
  input  logic             clk,
  input  logic             rst,
  gfx_host_bridge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(HALF_PERIOD);

  typedef struct packed {
    logic       write;
    logic [3:0] rs;
    logic [7:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            wrap, fall, rise;
  req_t            mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_pushed;
  logic            push, pop, empty;
  req_t            head;

  assign wrap  = (cnt == CW'(HALF_PERIOD - 1));
  assign fall  = wrap && bus.bus_clk;   // launch point
  assign rise  = wrap && !bus.bus_clk;
  assign empty = (count == '0);
  assign push  = bus.req_valid && bus.req_ready;
  assign pop   = fall && !empty;
  assign head  = mem[rd_ptr];
  assign bus.busy = !empty || !bus.cs_n;

  // Ready ignores a same-clk pop, so space freed by a pop only shows up one
  // clk later; it can never admit a push into a full FIFO.
  assign count_pushed = count + (AW+1)'(push);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{bus.req_write, bus.req_rs, bus.req_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.req_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count         <= count + (AW+1)'(push) - (AW+1)'(pop);
      bus.req_ready <= (count_pushed < (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fall && !empty) state_nx = LOW;
      LOW:     if (rise) state_nx = HIGH;
      HIGH:    if (fall) state_nx = empty ? IDLE : LOW;
      default: state_nx = IDLE;
    endcase
  end

  // Bus clock and bus outputs; outputs only move at the launch point.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      bus.bus_clk   <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.rs        <= '0;
      bus.wren_n    <= 1'b1;
      bus.data_o    <= '0;
      bus.data_oe   <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (wrap) begin
        cnt         <= '0;
        bus.bus_clk <= ~bus.bus_clk;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (fall) begin
        // last clk of the high phase: the adapter drives read data now
        if (state == HIGH && bus.wren_n) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= bus.data_i;
        end
        if (pop) begin
          bus.cs_n    <= 1'b0;
          bus.rs      <= head.rs;
          bus.wren_n  <= ~head.write;
          bus.data_o  <= head.wdata;
          bus.data_oe <= head.write;
        end else begin
          bus.cs_n    <= 1'b1;
          bus.wren_n  <= 1'b1;
          bus.data_oe <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_gfx_host_bridge.sv
// Scoreboard bench for gfx_host_bridge (HALF_PERIOD=4, FIFO_DEPTH=4).
// Stimulus pushes expected bus cycles / read responses into queues; a
// negedge monitor pops and compares whenever a bus cycle launches or
// rsp_valid pulses. A few cycle-exact timing points are checked directly.
module tb_gfx_host_bridge;
  typedef struct {
    logic       w;
    logic [3:0] rs;
    logic [7:0] d;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0, base = 0;
  int   n_chk = 0, n_fail = 0;
  int   lowcyc = 0, rspcnt = 0;
  logic [7:0] adapt [16];
  txn_t exp_bus [$];
  logic [7:0] exp_rsp [$];

  gfx_host_bridge_if bif ();

  gfx_host_bridge #(.HALF_PERIOD(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // adapter model: drives read data only during the high phase of a read
  assign bif.data_i = (bif.bus_clk && !bif.cs_n && bif.wren_n) ? adapt[bif.rs] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic       p_valid = 1'b0, p_bclk = 1'b0;
  logic [14:0] p_snap = '0;
  always @(negedge clk) begin
    logic       fall;
    logic [14:0] snap;
    txn_t       t;
    logic [7:0] r;
    snap = {bif.cs_n, bif.rs, bif.wren_n, bif.data_o, bif.data_oe};
    fall = p_bclk && !bif.bus_clk;
    if (!rst) begin
      if (!bif.cs_n) lowcyc++;
      if (p_valid && !fall) check("bus_stable", {17'd0, snap}, {17'd0, p_snap});
      if (fall && !bif.cs_n) begin
        if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          t = exp_bus.pop_front();
          check("bus_txn", {bif.rs, bif.wren_n, bif.data_oe, t.w ? bif.data_o : 8'h00},
                           {t.rs, ~t.w, t.w, t.w ? t.d : 8'h00});
        end
      end
      if (fall && bif.cs_n) check("bus_idle", {bif.wren_n, bif.data_oe}, 2'b10);
      if (bif.rsp_valid) begin
        rspcnt++;
        if (exp_rsp.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_rdata", bif.rsp_rdata, r);
        end
      end
    end
    p_valid = !rst;
    p_bclk  = bif.bus_clk;
    p_snap  = snap;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    bif.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_bus.delete();
    exp_rsp.delete();
    base = cyc;
    rst = 1'b0;
  endtask

  task automatic wait_until(input int k);
    while ((cyc - base) < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic w, input logic [3:0] r, input logic [7:0] d,
                      input logic [7:0] rexp, output int acc);
    logic ok;
    int   n;
    txn_t t;
    bif.req_valid = 1'b1;
    bif.req_write = w;
    bif.req_rs    = r;
    bif.req_wdata = d;
    acc = -1;
    n   = 0;
    while (acc < 0 && n < 60) begin
      ok = bif.req_ready;
      @(posedge clk);
      #1;
      n++;
      if (ok) acc = cyc - base;
    end
    bif.req_valid = 1'b0;
    if (acc < 0) check("send_timeout", 0, 1);
    else begin
      t = '{w, r, d};
      exp_bus.push_back(t);
      if (!w) exp_rsp.push_back(rexp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, lb, rb;
    for (int i = 0; i < 16; i++) adapt[i] = 8'h00;
    adapt[1] = 8'h5A;
    adapt[2] = 8'h77;
    adapt[4] = 8'hC3;
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_rs    = 4'h0;
    bif.req_wdata = 8'h00;

    // 1: reset values and bus clock phase
    do_reset();
    check("rst_cs_n",    bif.cs_n,      1);
    check("rst_wren_n",  bif.wren_n,    1);
    check("rst_data_oe", bif.data_oe,   0);
    check("rst_ready",   bif.req_ready, 1);
    check("rst_busy",    bif.busy,      0);
    check("rst_bus_clk", bif.bus_clk,   0);
    check("rst_rsp",     bif.rsp_valid, 0);
    check("rst_rs_data", {bif.rs, bif.data_o}, 12'h000);
    for (int k = 1; k <= 9; k++) begin
      wait_until(k);
      check($sformatf("bus_clk_%0d", k), bif.bus_clk, (k >= 4 && k < 8) ? 1 : 0);
    end

    // 2: single write
    do_reset();
    send(1'b1, 4'd1, 8'h41, 8'h00, acc);
    check("t2_accept", acc, 1);
    wait_until(7);  check("t2_cs_pre",  bif.cs_n, 1);
    wait_until(8);  check("t2_cs_on",   bif.cs_n, 0);
    check("t2_busy", bif.busy, 1);
    wait_until(15); check("t2_cs_hold", bif.cs_n, 0);
    wait_until(16); check("t2_cs_off",  bif.cs_n, 1);
    wait_until(20); check("t2_drained", exp_bus.size(), 0);

    // 3: single read
    do_reset();
    send(1'b0, 4'd1, 8'h00, 8'h5A, acc);
    wait_until(8);
    check("t3_ctrl", {bif.cs_n, bif.wren_n, bif.data_oe}, 3'b010);
    wait_until(15); check("t3_rsp_pre", bif.rsp_valid, 0);
    wait_until(16); check("t3_rsp",     {bif.rsp_valid, bif.rsp_rdata}, 9'h15A);
    wait_until(17); check("t3_rsp_end", bif.rsp_valid, 0);
    wait_until(20); check("t3_drained", exp_rsp.size(), 0);

    // 4: five back-to-back writes, FIFO fills
    do_reset();
    lb = lowcyc;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'(i + 2), 8'(8'hA0 + i), 8'h00, acc);
      check($sformatf("t4_accept_%0d", i), acc, i + 1);
    end
    check("t4_full", bif.req_ready, 0);
    send(1'b1, 4'd9, 8'hA9, 8'h00, acc);
    check("t4_accept_5th", acc, 10);
    wait_until(47); check("t4_cs_last", bif.cs_n, 0);
    wait_until(48); check("t4_cs_off",  bif.cs_n, 1);
    wait_until(56);
    check("t4_low_clks", lowcyc - lb, 40);
    check("t4_drained",  exp_bus.size(), 0);

    // 5: write then read, in order
    do_reset();
    send(1'b1, 4'd3, 8'h10, 8'h00, acc);
    send(1'b0, 4'd4, 8'h00, 8'hC3, acc);
    wait_until(16); check("t5_rsp_none", bif.rsp_valid, 0);
    wait_until(24); check("t5_rsp", {bif.rsp_valid, bif.rsp_rdata}, 9'h1C3);
    wait_until(32);
    check("t5_drained", exp_bus.size() + exp_rsp.size(), 0);

    // 6: reset during a read's high phase
    do_reset();
    send(1'b0, 4'd2, 8'h00, 8'h77, acc);
    send(1'b1, 4'd5, 8'h11, 8'h00, acc);
    send(1'b1, 4'd6, 8'h22, 8'h00, acc);
    wait_until(14);
    check("t6_in_high", {bif.bus_clk, bif.cs_n}, 2'b10);
    rst = 1'b1;
    exp_bus.delete();
    exp_rsp.delete();
    @(posedge clk); #1;
    check("t6_rst_vals", {bif.cs_n, bif.data_oe, bif.busy, bif.req_ready, bif.rsp_valid}, 5'b10010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    lb = lowcyc;
    rb = rspcnt;
    repeat (40) @(posedge clk);
    #1;
    check("t6_no_bus", lowcyc - lb, 0);
    check("t6_no_rsp", rspcnt - rb, 0);
    check("t6_idle",   bif.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
